pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock shared with PC and all four stage registers.
REQ-002 reset_n  input  1  reset, synchronous, active-low.
REQ-003 fd_rs  input  5  source register 0 of the instruction held in the FD stage register.
REQ-004 fd_rt  input  5  source register 1 of the instruction in FD.
REQ-005 fd_uses_rt  input  1  FD instruction reads fd_rt.
REQ-006 de_mem_read  input  1  DE instruction is a load.
REQ-007 de_dst_reg  input  5  DE destination register.
REQ-008 em_branch_taken  input  1  EM instruction redirects the PC (branch with zero result, or jump).
REQ-009 mem_req  input  1  EM instruction accesses data memory this cycle.
REQ-010 mem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_wren, fd_wren, de_wren, em_wren, mw_wren  output  1 each  write enables for PC and the four stage registers.
REQ-012 fd_flush, de_flush, em_flush  output  1 each  load a bubble (all fields zero) into FD/DE/EM at the next edge.
REQ-013 pc_sel_branch  output  1  PC next value is the EM branch_pc, not the sequential PC.

Function
REQ-014 The FSM SHALL have two states, RUN and MEM_WAIT, with the state held in a register.
REQ-015 Outputs SHALL be combinational from state and inputs; the register-to-output path SHALL contain no extra pipeline delay.
REQ-016 Priority in RUN SHALL be memory wait > branch flush > load-use stall > normal advance.
REQ-017 Normal advance SHALL drive all five wren=1, all flush=0, pc_sel_branch=0.
REQ-018 In RUN, mem_req=1 with mem_ready=0 SHALL drive all wren=0 and all flush=0, and move to MEM_WAIT at the next edge.
REQ-019 In RUN, mem_req=1 with mem_ready=1 in the same cycle SHALL not stall.
REQ-020 In MEM_WAIT, all wren SHALL be 0 while mem_ready=0; em_branch_taken and hazard inputs SHALL be ignored.
REQ-021 In MEM_WAIT, mem_ready=1 SHALL apply RUN rules for that cycle, excluding REQ-018, and return to RUN at the next edge.
REQ-022 A branch flush SHALL drive pc_sel_branch=1, all wren=1, fd_flush=de_flush=em_flush=1, in exactly one cycle.
REQ-023 Load-use stall condition: de_mem_read=1, de_dst_reg!=0, and de_dst_reg equal to fd_rs, or equal to fd_rt with fd_uses_rt=1.
REQ-024 A load-use stall SHALL drive pc_wren=fd_wren=0, de_wren=1, de_flush=1, and em_wren=mw_wren=1, for one cycle.
REQ-025 After the bubble, the load sits in EM and the condition clears without extra state.
REQ-026 A branch flush in the same cycle as a load-use condition SHALL override it: no stall, full flush.

Reset
REQ-027 While reset_n=0: all wren, flush and pc_sel_branch outputs SHALL be 0, and the state SHALL load RUN at the edge.
REQ-028 Reset asserted during MEM_WAIT SHALL abandon the wait; the first cycle after release is RUN.

Configuration
REQ-029 With macro PIPE_HAZARD_CTRL_PERF_EN defined, outputs stall_cycles[31:0] and flush_count[31:0] SHALL exist.
REQ-030 stall_cycles SHALL increment once per cycle in which pc_wren=0 and reset_n=1.
REQ-031 flush_count SHALL increment once per branch flush.
REQ-032 Both counters SHALL reset to 0, wrap modulo 2^32, and change no other behaviour.
REQ-033 Without the macro, neither the counters nor their ports SHALL exist.

Structure
REQ-034 A shared package SHALL hold the state enum (RUN=0, MEM_WAIT=1) and the REG_ZERO=5'd0 constant.
REQ-035 A sub-module, pipe_hazard_detect, SHALL hold the combinational load-use compare.

Verification
REQ-036 Load-use: de_mem_read=1, de_dst_reg=3, fd_rs=3 -> one cycle of pc_wren=fd_wren=0, de_flush=1; the next cycle is normal advance.
REQ-037 Zero register: de_mem_read=1, de_dst_reg=0, fd_rs=0 -> no stall.
REQ-038 fd_rt path: de_dst_reg=5, fd_rt=5, fd_uses_rt=0 -> no stall; with fd_uses_rt=1 -> stall.
REQ-039 Memory wait: mem_req=1, mem_ready low for 3 cycles -> 3 cycles of all-wren=0, then one advance cycle with mem_ready=1, then RUN (stall_cycles +3 when the macro is enabled).
REQ-040 Branch together with load-use: em_branch_taken=1 plus the REQ-036 condition -> pc_sel_branch=1, three flushes, all wren=1, flush_count +1.
REQ-041 Reset mid-wait: reset_n=0 for 1 cycle during MEM_WAIT -> all outputs 0; after release, state is RUN and counters are 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared controller state encoding and the hard-wired zero register index
package pipe_hazard_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard status from the pipeline (master) and stage control back from the controller (slave)
interface pipe_hazard_ctrl_if;
  logic [4:0] fd_rs;
  logic [4:0] fd_rt;
  logic       fd_uses_rt;
  logic       de_mem_read;
  logic [4:0] de_dst_reg;
  logic       em_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_wren;
  logic       fd_wren;
  logic       de_wren;
  logic       em_wren;
  logic       mw_wren;
  logic       fd_flush;
  logic       de_flush;
  logic       em_flush;
  logic       pc_sel_branch;
  modport master (
    output fd_rs, fd_rt, fd_uses_rt, de_mem_read, de_dst_reg, em_branch_taken, mem_req, mem_ready,
    input  pc_wren, fd_wren, de_wren, em_wren, mw_wren, fd_flush, de_flush, em_flush, pc_sel_branch
  );
  modport slave (
    input  fd_rs, fd_rt, fd_uses_rt, de_mem_read, de_dst_reg, em_branch_taken, mem_req, mem_ready,
    output pc_wren, fd_wren, de_wren, em_wren, mw_wren, fd_flush, de_flush, em_flush, pc_sel_branch
  );
endinterface

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: combinational load-use compare between the DE load and the FD sources
module pipe_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       de_mem_read,
  input  logic [4:0] de_dst_reg,
  input  logic [4:0] fd_rs,
  input  logic [4:0] fd_rt,
  input  logic       fd_uses_rt,
  output logic       load_use
);
  assign load_use = de_mem_read && (de_dst_reg != REG_ZERO) &&
                    ((de_dst_reg == fd_rs) || (fd_uses_rt && (de_dst_reg == fd_rt)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for a 5-stage pipeline (memory wait > branch flush > load-use > advance)
// Ports: clk, reset_n (sync, active-low), bus (pipe_hazard_ctrl_if.slave).
// With PIPE_HAZARD_CTRL_PERF_EN defined, adds stall_cycles[31:0] and flush_count[31:0].
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input logic clk,
  input logic reset_n,
  pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);
  state_t state;
  logic load_use, hold, adv, branch, stall;
  pipe_hazard_detect u_detect (
    .de_mem_read(bus.de_mem_read),
    .de_dst_reg (bus.de_dst_reg),
    .fd_rs      (bus.fd_rs),
    .fd_rt      (bus.fd_rt),
    .fd_uses_rt (bus.fd_uses_rt),
    .load_use   (load_use)
  );
  // In MEM_WAIT only mem_ready matters; once it rises the cycle follows normal RUN priority.
  always_comb begin
    hold   = (state == RUN) ? (bus.mem_req && !bus.mem_ready) : !bus.mem_ready;
    adv    = reset_n && !hold;
    branch = adv && bus.em_branch_taken;
    stall  = adv && !branch && load_use;
  end
  assign bus.pc_wren       = adv && !stall;
  assign bus.fd_wren       = adv && !stall;
  assign bus.de_wren       = adv;
  assign bus.em_wren       = adv;
  assign bus.mw_wren       = adv;
  assign bus.fd_flush      = branch;
  assign bus.de_flush      = branch || stall;
  assign bus.em_flush      = branch;
  assign bus.pc_sel_branch = branch;
  always_ff @(posedge clk)
    state <= (reset_n && hold) ? MEM_WAIT : RUN;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, !bus.pc_wren};
      flush_count  <= flush_count + {31'd0, branch};
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam logic [8:0] NORM  = 9'b11111_0000;
  localparam logic [8:0] STALL = 9'b00111_0100;
  localparam logic [8:0] BR    = 9'b11111_1111;
  localparam logic [8:0] HOLD  = 9'b00000_0000;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  pipe_hazard_ctrl_if bus ();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
  logic [31:0] s0, f0;
`endif
  pipe_hazard_ctrl dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] outs();
    return {bus.pc_wren, bus.fd_wren, bus.de_wren, bus.em_wren, bus.mw_wren,
            bus.fd_flush, bus.de_flush, bus.em_flush, bus.pc_sel_branch};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.fd_rs = 5'd0; bus.fd_rt = 5'd0; bus.fd_uses_rt = 1'b0;
    bus.de_mem_read = 1'b0; bus.de_dst_reg = 5'd0; bus.em_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask
  task automatic load_use3();
    bus.de_mem_read = 1'b1; bus.de_dst_reg = 5'd3; bus.fd_rs = 5'd3;
  endtask
  task automatic test_reset();
    idle();
    load_use3();
    bus.em_branch_taken = 1'b1;
    bus.mem_req = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== HOLD) begin errors++; $display("FAIL reset_outs got %b want %b", outs(), HOLD); end
    tick();
    tick();
    reset_n = 1'b1;
    idle();
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL reset_release got %b want %b", outs(), NORM); end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
`endif
    tick();
  endtask
  task automatic test_load_use();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    s0 = stall_cycles; f0 = flush_count;
`endif
    idle();
    load_use3();
    #1;
    checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL load_use_rs got %b want %b", outs(), STALL); end
    tick();
    idle();
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL load_use_after got %b want %b", outs(), NORM); end
    tick();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checks++;
    if (stall_cycles - s0 !== 32'd1 || flush_count - f0 !== 32'd0) begin
      errors++; $display("FAIL load_use_counters got %0d/%0d want 1/0", stall_cycles - s0, flush_count - f0);
    end
`endif
  endtask
  task automatic test_zero_reg();
    idle();
    bus.de_mem_read = 1'b1; bus.de_dst_reg = 5'd0; bus.fd_rs = 5'd0; bus.fd_rt = 5'd0; bus.fd_uses_rt = 1'b1;
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL zero_reg got %b want %b", outs(), NORM); end
    tick();
    idle();
    bus.de_mem_read = 1'b0; bus.de_dst_reg = 5'd3; bus.fd_rs = 5'd3;
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL not_load got %b want %b", outs(), NORM); end
    tick();
  endtask
  task automatic test_rt_path();
    idle();
    bus.de_mem_read = 1'b1; bus.de_dst_reg = 5'd5; bus.fd_rt = 5'd5; bus.fd_rs = 5'd1; bus.fd_uses_rt = 1'b0;
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL rt_unused got %b want %b", outs(), NORM); end
    tick();
    bus.fd_uses_rt = 1'b1;
    #1;
    checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL rt_used got %b want %b", outs(), STALL); end
    tick();
  endtask
  task automatic test_mem_wait();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    s0 = stall_cycles; f0 = flush_count;
`endif
    idle();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL mem_ready_same got %b want %b", outs(), NORM); end
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin load_use3(); bus.em_branch_taken = 1'b1; end
      #1;
      checks++;
      if (outs() !== HOLD) begin errors++; $display("FAIL mem_wait_%0d got %b want %b", i, outs(), HOLD); end
      tick();
    end
    idle();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL mem_done got %b want %b", outs(), NORM); end
    tick();
    idle();
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL mem_back_run got %b want %b", outs(), NORM); end
    tick();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checks++;
    if (stall_cycles - s0 !== 32'd3 || flush_count - f0 !== 32'd0) begin
      errors++; $display("FAIL mem_wait_counters got %0d/%0d want 3/0", stall_cycles - s0, flush_count - f0);
    end
`endif
    bus.mem_req = 1'b1;
    #1;
    tick();
    bus.mem_ready = 1'b1;
    load_use3();
    #1;
    checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL wait_exit_load_use got %b want %b", outs(), STALL); end
    tick();
    idle();
    bus.mem_req = 1'b1;
    #1;
    tick();
    bus.mem_ready = 1'b1;
    bus.em_branch_taken = 1'b1;
    #1;
    checks++;
    if (outs() !== BR) begin errors++; $display("FAIL wait_exit_branch got %b want %b", outs(), BR); end
    tick();
    idle();
  endtask
  task automatic test_branch_load_use();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    s0 = stall_cycles; f0 = flush_count;
`endif
    idle();
    load_use3();
    bus.em_branch_taken = 1'b1;
    #1;
    checks++;
    if (outs() !== BR) begin errors++; $display("FAIL branch_load_use got %b want %b", outs(), BR); end
    tick();
    idle();
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL branch_after got %b want %b", outs(), NORM); end
    tick();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checks++;
    if (stall_cycles - s0 !== 32'd0 || flush_count - f0 !== 32'd1) begin
      errors++; $display("FAIL branch_counters got %0d/%0d want 0/1", stall_cycles - s0, flush_count - f0);
    end
`endif
  endtask
  task automatic test_reset_mid_wait();
    idle();
    bus.mem_req = 1'b1;
    #1;
    checks++;
    if (outs() !== HOLD) begin errors++; $display("FAIL rmw_enter got %b want %b", outs(), HOLD); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== HOLD) begin errors++; $display("FAIL rmw_reset got %b want %b", outs(), HOLD); end
    tick();
    reset_n = 1'b1;
    bus.mem_req = 1'b0;
    #1;
    checks++;
    if (outs() !== NORM) begin errors++; $display("FAIL rmw_run got %b want %b", outs(), NORM); end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL rmw_counters got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
`endif
    tick();
  endtask
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_rt_path();
    test_mem_wait();
    test_branch_load_use();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
